// File: rtl/fifo_sync_param.sv
// Single-clock synchronous FIFO with integrated RAM, registered read data and occupancy flags.
// Define FIFO_ERROR_EN to enable the sticky overflow/underflow error output.
module fifo_sync_param #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned ADDR_WIDTH      = 3,
    parameter int unsigned ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned ALMOST_EMPTY_TH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] FIFO_data_in,
    input  logic                  push,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] FIFO_data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  error
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   AF_TH    = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0]   AE_TH    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH:0]     count;
    logic                    push_ok;
    logic                    pop_ok;

    // A push into a full FIFO is accepted when a pop frees the slot in the same edge.
    assign push_ok = push & (~full | pop);
    assign pop_ok  = pop & ~empty;

    assign full         = (state == ST_FULL);
    assign empty        = (state == ST_EMPTY);
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);
    assign fifo_count   = count;

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (push_ok && !pop_ok)
                    state_next = (DEPTH == 1) ? ST_FULL : ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (pop_ok && !push_ok && count == CNT_ONE)
                    state_next = ST_EMPTY;
                else if (push_ok && !pop_ok && count == CNT_LAST)
                    state_next = ST_FULL;
            end
            ST_FULL: begin
                if (pop_ok && !push_ok)
                    state_next = (DEPTH == 1) ? ST_EMPTY : ST_PARTIAL;
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_next;
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // RAM contents are never reset; a push in the reset cycle is simply not stored.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem[wr_ptr] <= FIFO_data_in;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            FIFO_data_out <= '0;
            data_valid    <= 1'b0;
        end else begin
            data_valid <= pop_ok;
            if (pop_ok)
                FIFO_data_out <= mem[rd_ptr];
        end
    end

`ifdef FIFO_ERROR_EN
    logic error_q;

    always_ff @(posedge clk) begin
        if (reset)
            error_q <= 1'b0;
        else if ((push && !push_ok) || (pop && !pop_ok))
            error_q <= 1'b1;
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param at depth 4 (ADDR_WIDTH=2).
module tb_fifo_sync_param;

`ifdef FIFO_ERROR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] FIFO_data_in;
    logic       push;
    logic       pop;
    logic [7:0] FIFO_data_out;
    logic       data_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] fifo_count;
    logic       error;

    int checks = 0;
    int errors = 0;

    fifo_sync_param #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (2),
        .ALMOST_FULL_TH (3),
        .ALMOST_EMPTY_TH(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .FIFO_data_in (FIFO_data_in),
        .push         (push),
        .pop          (pop),
        .FIFO_data_out(FIFO_data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fifo_count   (fifo_count),
        .error        (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cycle(input logic p, input logic q, input logic [7:0] d);
        push         = p;
        pop          = q;
        FIFO_data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d, input logic [2:0] cnt);
        cycle(1'b0, 1'b1, 8'h00);
        check({tag, "_data"}, 32'(FIFO_data_out), 32'(d));
        check({tag, "_valid"}, 32'(data_valid), 32'd1);
        check({tag, "_count"}, 32'(fifo_count), 32'(cnt));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        reset = 1'b0;
    endtask

    task automatic fill4();
        cycle(1'b1, 1'b0, 8'h11);
        cycle(1'b1, 1'b0, 8'h22);
        cycle(1'b1, 1'b0, 8'h33);
        cycle(1'b1, 1'b0, 8'h44);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; FIFO_data_in = 8'h00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_dout", 32'(FIFO_data_out), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        reset = 1'b0;

        // Fill with flag tracking
        cycle(1'b1, 1'b0, 8'h11);
        check("p1_count", 32'(fifo_count), 32'd1);
        check("p1_empty", 32'(empty), 32'd0);
        check("p1_ae", 32'(almost_empty), 32'd1);
        cycle(1'b1, 1'b0, 8'h22);
        check("p2_ae", 32'(almost_empty), 32'd0);
        check("p2_af", 32'(almost_full), 32'd0);
        cycle(1'b1, 1'b0, 8'h33);
        check("p3_af", 32'(almost_full), 32'd1);
        check("p3_full", 32'(full), 32'd0);
        cycle(1'b1, 1'b0, 8'h44);
        check("p4_full", 32'(full), 32'd1);
        check("p4_count", 32'(fifo_count), 32'd4);

        // Drain back to back
        pop_expect("d1", 8'h11, 3'd3);
        check("d1_full", 32'(full), 32'd0);
        pop_expect("d2", 8'h22, 3'd2);
        pop_expect("d3", 8'h33, 3'd1);
        check("d3_ae", 32'(almost_empty), 32'd1);
        pop_expect("d4", 8'h44, 3'd0);
        check("d4_empty", 32'(empty), 32'd1);
        cycle(1'b0, 1'b0, 8'h00);
        check("idle_valid", 32'(data_valid), 32'd0);
        check("idle_dout_hold", 32'(FIFO_data_out), 32'h44);
        check("noerr", 32'(error), 32'd0);

        // Overflow
        fill4();
        cycle(1'b1, 1'b0, 8'h55);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_error", 32'(error), 32'(ERR_EN));
        pop_expect("o1", 8'h11, 3'd3);
        pop_expect("o2", 8'h22, 3'd2);
        pop_expect("o3", 8'h33, 3'd1);
        pop_expect("o4", 8'h44, 3'd0);
        check("ovf_err_sticky", 32'(error), 32'(ERR_EN));

        // Simultaneous push/pop at full, wrap
        fill4();
        cycle(1'b1, 1'b1, 8'hAA);
        check("fpp_data", 32'(FIFO_data_out), 32'h11);
        check("fpp_valid", 32'(data_valid), 32'd1);
        check("fpp_count", 32'(fifo_count), 32'd4);
        check("fpp_full", 32'(full), 32'd1);
        pop_expect("w1", 8'h22, 3'd3);
        pop_expect("w2", 8'h33, 3'd2);
        pop_expect("w3", 8'h44, 3'd1);
        pop_expect("w4", 8'hAA, 3'd0);
        check("w4_empty", 32'(empty), 32'd1);

        // Simultaneous push/pop at empty: underflow
        do_reset();
        check("r2_error", 32'(error), 32'd0);
        cycle(1'b1, 1'b1, 8'h77);
        check("epp_count", 32'(fifo_count), 32'd1);
        check("epp_valid", 32'(data_valid), 32'd0);
        check("epp_empty", 32'(empty), 32'd0);
        check("epp_error", 32'(error), 32'(ERR_EN));
        pop_expect("e1", 8'h77, 3'd0);

        // Reset mid-burst with push asserted
        cycle(1'b1, 1'b0, 8'h01);
        cycle(1'b1, 1'b0, 8'h02);
        check("pre_rst_count", 32'(fifo_count), 32'd2);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 8'h03);
        reset = 1'b0;
        check("mrst_count", 32'(fifo_count), 32'd0);
        check("mrst_empty", 32'(empty), 32'd1);
        check("mrst_valid", 32'(data_valid), 32'd0);
        check("mrst_error", 32'(error), 32'd0);
        check("mrst_dout", 32'(FIFO_data_out), 32'd0);
        cycle(1'b0, 1'b1, 8'h00);
        check("post_pop_valid", 32'(data_valid), 32'd0);
        check("post_pop_count", 32'(fifo_count), 32'd0);
        check("post_pop_empty", 32'(empty), 32'd1);
        check("post_pop_error", 32'(error), 32'(ERR_EN));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
